// File: rtl/alarm_scheduler_if.sv
`timescale 1ns/1ps
// alarm_scheduler_if: word-indexed register bus between a host and the alarm scheduler.
interface alarm_scheduler_if;
   logic [7:0]  addrIn;
   logic [7:0]  addrOut;
   logic [3:0]  sizeDecode;
   logic [31:0] dataIn;
   logic [31:0] dataOut;

   modport master (
      output addrIn,
      output addrOut,
      output sizeDecode,
      output dataIn,
      input  dataOut
   );

   modport slave (
      input  addrIn,
      input  addrOut,
      input  sizeDecode,
      input  dataIn,
      output dataOut
   );
endinterface

// File: rtl/alarm_scheduler.sv
`timescale 1ns/1ps
// alarm_scheduler: multi-channel millisecond alarms scanned one channel per cycle, level irq.
// Define ALARM_SCHED_OVERRUN_EN to build the per-channel 4-bit overrun counters.
module alarm_scheduler #(
   parameter int NUM_CH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   alarm_scheduler_if.slave bus,
   input  logic [31:0]      msTime,
   output logic             irq
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t            state;
   state_t            next_state;
   logic [2:0]        scan_idx;
   logic [2:0]        next_idx;

   logic              ctrl_en;
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] mask;
   logic [NUM_CH-1:0] armed;
   logic [31:0]       deadline [NUM_CH];
   logic [31:0]       period   [NUM_CH];

   logic              wr_en;
   logic [31:0]       lane_mask;
   logic              ctrl_wr;
   logic              pend_wr;
   logic              mask_wr;
   logic [NUM_CH-1:0] dl_wr;
   logic [NUM_CH-1:0] pr_wr;
   logic [NUM_CH-1:0] pend_clr;

   logic [31:0]       sel_deadline;
   logic              sel_armed;
   logic [31:0]       slack;
   logic [NUM_CH-1:0] fire;

   logic [31:0]       overrun_word;
   logic [31:0]       read_word;

   function automatic logic [31:0] merge(input logic [31:0] old_val,
                                         input logic [31:0] wdata,
                                         input logic [31:0] lanes);
      return (old_val & ~lanes) | (wdata & lanes);
   endfunction

   always_comb begin
      wr_en     = |bus.sizeDecode;
      lane_mask = {{8{bus.sizeDecode[3]}}, {8{bus.sizeDecode[2]}},
                   {8{bus.sizeDecode[1]}}, {8{bus.sizeDecode[0]}}};
      ctrl_wr   = wr_en && (bus.addrIn == 8'd0);
      pend_wr   = wr_en && (bus.addrIn == 8'd1);
      mask_wr   = wr_en && (bus.addrIn == 8'd2);
      dl_wr     = '0;
      pr_wr     = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         dl_wr[ch] = wr_en && (bus.addrIn == 8'(4 + 2 * ch));
         pr_wr[ch] = wr_en && (bus.addrIn == 8'(5 + 2 * ch));
      end
      pend_clr = pend_wr ? (bus.dataIn[NUM_CH-1:0] & lane_mask[NUM_CH-1:0]) : '0;
   end

   // Only the channel under the scan pointer is compared; the sign of the
   // difference makes the test immune to msTime wrapping through zero.
   always_comb begin
      sel_deadline = '0;
      sel_armed    = 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (scan_idx == 3'(ch)) begin
            sel_deadline = deadline[ch];
            sel_armed    = armed[ch];
         end
      end
      slack = msTime - sel_deadline;
      fire  = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         fire[ch] = (state == SCAN) && sel_armed && !slack[31] && (scan_idx == 3'(ch));
      end
   end

   always_comb begin
      next_state = state;
      next_idx   = scan_idx;
      case (state)
         IDLE: begin
            next_idx = '0;
            if (ctrl_en) next_state = SCAN;
         end
         SCAN: begin
            next_idx = (scan_idx == 3'(NUM_CH - 1)) ? 3'd0 : scan_idx + 3'd1;
            if (!ctrl_en) begin
               next_state = IDLE;
               next_idx   = '0;
            end
         end
         default: begin
            next_state = IDLE;
            next_idx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         scan_idx <= '0;
      end else begin
         state    <= next_state;
         scan_idx <= next_idx;
      end
   end

   // A host write to a channel's timing registers overrides the scanner's
   // reload in the same cycle and leaves the channel armed.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ctrl_en <= 1'b0;
         pending <= '0;
         mask    <= '0;
         armed   <= '0;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            deadline[ch] <= '0;
            period[ch]   <= '0;
         end
      end else begin
         if (ctrl_wr && bus.sizeDecode[0]) ctrl_en <= bus.dataIn[0];
         pending <= (pending & ~pend_clr) | fire;
         if (mask_wr) begin
            mask <= (mask & ~lane_mask[NUM_CH-1:0]) |
                    (bus.dataIn[NUM_CH-1:0] & lane_mask[NUM_CH-1:0]);
         end
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (dl_wr[ch]) begin
               deadline[ch] <= merge(deadline[ch], bus.dataIn, lane_mask);
               armed[ch]    <= 1'b1;
            end else if (pr_wr[ch] && fire[ch]) begin
               armed[ch]    <= 1'b1;
            end else if (fire[ch]) begin
               if (period[ch] != 32'd0) deadline[ch] <= deadline[ch] + period[ch];
               else                     armed[ch]    <= 1'b0;
            end
            if (pr_wr[ch]) period[ch] <= merge(period[ch], bus.dataIn, lane_mask);
         end
      end
   end

`ifdef ALARM_SCHED_OVERRUN_EN
   logic       ovr_wr;
   logic [3:0] ovr_cnt [NUM_CH];

   assign ovr_wr = |bus.sizeDecode && (bus.addrIn == 8'd3);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int ch = 0; ch < NUM_CH; ch++) ovr_cnt[ch] <= '0;
      end else if (ovr_wr) begin
         for (int ch = 0; ch < NUM_CH; ch++) ovr_cnt[ch] <= '0;
      end else begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (fire[ch] && pending[ch] && (ovr_cnt[ch] != 4'hF)) ovr_cnt[ch] <= ovr_cnt[ch] + 4'd1;
         end
      end
   end

   always_comb begin
      overrun_word = '0;
      for (int ch = 0; ch < NUM_CH; ch++) overrun_word[4*ch +: 4] = ovr_cnt[ch];
   end
`else
   assign overrun_word = '0;
`endif

   always_comb begin
      read_word = '0;
      case (bus.addrOut)
         8'd0: read_word = {31'b0, ctrl_en};
         8'd1: read_word = 32'(pending);
         8'd2: read_word = 32'(mask);
         8'd3: read_word = overrun_word;
         default: begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
               if (bus.addrOut == 8'(4 + 2 * ch))      read_word = deadline[ch];
               else if (bus.addrOut == 8'(5 + 2 * ch)) read_word = period[ch];
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.dataOut <= '0;
         irq         <= 1'b0;
      end else begin
         bus.dataOut <= read_word;
         irq         <= |(pending & mask);
      end
   end

endmodule
